// File: rtl/fetch_stage_if.sv
// Fetch stage bus: instruction memory port plus the decode-side bundle.
interface fetch_stage_if #(
  parameter int PC_W    = 12,
  parameter int INSTR_W = 16
);
  logic               imem_en;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               jflag;
  logic [PC_W-1:0]    jdest;
  logic               id_valid;
  logic [PC_W-1:0]    id_pc;
  logic [INSTR_W-1:0] id_instr;

  modport master (
    output imem_en, imem_addr,
    output id_valid, id_pc, id_instr,
    input  imem_rdata, stall, jflag, jdest
  );

  modport slave (
    input  imem_en, imem_addr,
    input  id_valid, id_pc, id_instr,
    output imem_rdata, stall, jflag, jdest
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the pc, drives sync imem, handles stall,
// branch flush and HLT.
module fetch_stage #(
  parameter int PC_W    = 12,
  parameter int INSTR_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus,
  output logic          halted,
  output logic [15:0]   fetch_count
);

  typedef enum logic [1:0] {
    FILL,
    RUN,
    HALT
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] id_pc_q, id_pc_d;
  logic            id_valid_q, id_valid_d;
  logic [15:0]     cnt_q, cnt_d;

  logic accept, take, hlt, en;

  assign accept = id_valid_q & ~bus.stall;
  assign take   = accept & bus.jflag;
  assign hlt    = accept
                & (bus.imem_rdata[15:14] == 2'b11)
                & (bus.imem_rdata[7:4] == 4'b1111);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    en         = 1'b0;
    unique case (state_q)
      FILL: begin
        en         = 1'b1;
        id_pc_d    = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 1'b1;
        id_valid_d = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        if (hlt) begin
          id_valid_d = 1'b0;
          state_d    = HALT;
        end else if (take) begin
          // drop the wrong-path word already in flight
          fetch_pc_d = bus.jdest;
          id_valid_d = 1'b0;
        end else if (id_valid_q & bus.stall) begin
          en = 1'b0;
        end else begin
          en         = 1'b1;
          id_pc_d    = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 1'b1;
          id_valid_d = 1'b1;
        end
      end
      HALT: begin
        id_valid_d = 1'b0;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      fetch_pc_q <= RESET_PC;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.imem_en   = en;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.id_valid  = id_valid_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_instr  = bus.imem_rdata;
  assign halted        = (state_q == HALT);
  assign fetch_count   = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic
// against a stream-level model of the presented pc sequence.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        halted;
  logic [15:0] fetch_count;

  fetch_stage_if #(.PC_W(12), .INSTR_W(16)) bus ();

  fetch_stage #(
    .PC_W(12), .INSTR_W(16), .RESET_PC(12'h000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .halted(halted),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [4096];

  always @(posedge clk)
    if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];

  int n_tests = 0;
  int n_fail  = 0;

  logic        m_valid;
  logic [11:0] m_pc;
  logic [11:0] m_tgt;
  logic        m_halted;
  int          m_cnt;

  function automatic logic is_hlt(input logic [15:0] w);
    return (w[15:14] == 2'b11) && (w[7:4] == 4'b1111);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_pc     = 12'h000;
    m_tgt    = 12'h000;
    m_halted = 1'b0;
    m_cnt    = 0;
  endtask

  task automatic step(input logic s, input logic j,
                      input logic [11:0] d, input logic r);
    logic acc, h, e;
    bus.stall = s;
    bus.jflag = j;
    bus.jdest = d;
    rst       = r;
    @(negedge clk);
    acc = m_valid && !s;
    h   = acc && is_hlt(mem[m_pc]);
    e   = !m_halted && !(m_valid && s) && !(acc && (h || j));
    chk("id_valid", 32'(bus.id_valid), 32'(m_valid));
    chk("imem_en", 32'(bus.imem_en), 32'(e));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
    if (m_valid) begin
      chk("id_pc", 32'(bus.id_pc), 32'(m_pc));
      chk("id_instr", 32'(bus.id_instr), 32'(mem[m_pc]));
    end else if (!m_halted) begin
      chk("imem_addr", 32'(bus.imem_addr), 32'(m_tgt));
    end
    if (r) begin
      model_reset();
    end else if (!m_halted) begin
      if (!m_valid) begin
        m_valid = 1'b1;
        m_pc    = m_tgt;
      end else if (!s) begin
        if (m_cnt < 16'hFFFF) m_cnt++;
        if (h) begin
          m_halted = 1'b1;
          m_valid  = 1'b0;
        end else if (j) begin
          m_valid = 1'b0;
          m_tgt   = d;
        end else begin
          m_pc = m_pc + 12'd1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++)
      mem[i] = 16'h1000 + 16'(i);
    mem[7] = 16'hC0F0;
    bus.stall = 1'b0;
    bus.jflag = 1'b0;
    bus.jdest = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    for (int i = 0; i < 3; i++) step(0, 0, 12'h000, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 12'h000, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 12'h000, 0);
    chk("pc_before_branch", 32'(bus.id_pc), 32'h5);
    step(1, 1, 12'h040, 0);
    step(1, 1, 12'h040, 0);
    step(0, 1, 12'h040, 0);
    step(0, 1, 12'h123, 0);
    chk("redirect_pc", 32'(bus.id_pc), 32'h040);
    step(0, 0, 12'h000, 0);
    step(0, 1, 12'h007, 0);
    step(0, 0, 12'h000, 0);
    step(0, 0, 12'h000, 0);
    for (int i = 0; i < 20; i++)
      step(1'($urandom), 1'($urandom), 12'($urandom), 0);
    step(0, 0, 12'h000, 1);
    mem[7] = 16'h1007;

    for (int i = 0; i < 400; i++)
      step(($urandom % 4) == 0, ($urandom % 6) == 0,
           12'($urandom), ($urandom % 97) == 0);

    for (int i = 0; i < 4 && !m_valid; i++)
      step(0, 0, 12'h000, 0);
    step(0, 1, 12'hFFE, 0);
    step(0, 0, 12'h000, 0);
    for (int i = 0; i < 70000; i++) step(0, 0, 12'h000, 0);
    chk("count_sat", 32'(fetch_count), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 16-bit core. It owns the 12-bit program counter and drives the synchronous instruction memory. It presents {pc, instr, valid} to the decode/branch stage and accepts the branch resolution (jflag, jdest) computed there on that same pc/instr. It also handles stalls, wrong-path flush and HLT.

Parameters:
PC_W, 12, program counter / instruction memory address width
INSTR_W, 16, instruction width
RESET_PC, 0, first fetch address after reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
imem_en  output  1  instruction memory read enable; memory holds imem_rdata when low
imem_addr  output  PC_W  instruction memory address (= fetch_pc register)
imem_rdata  input  INSTR_W  memory data, valid 1 cycle after an enabled address
stall  input  1  downstream cannot accept id_* this cycle
jflag  input  1  branch taken for the instruction currently on id_pc/id_instr
jdest  input  PC_W  branch target for that instruction
id_valid  output  1  id_pc/id_instr hold a real instruction
id_pc  output  PC_W  pc of instruction on id_instr
id_instr  output  INSTR_W  instruction (combinational pass-through of imem_rdata)
halted  output  1  HLT retired; fetch stopped
fetch_count  output  16  number of accepted instructions, saturating

Behaviour:
- Reset is synchronous and active-high (rst), on clk. State=FILL, fetch_pc=RESET_PC, id_pc=0, id_valid=0, halted=0, fetch_count=0.
- Internal registers: state {FILL, RUN, HALT}, fetch_pc, id_pc, id_valid, fetch_count.
- accept = id_valid & ~stall. take = accept & jflag. hlt = accept & (id_instr[15:14]==2'b11) & (id_instr[7:4]==4'b1111).
- FILL (one cycle): imem_en=1, addr=RESET_PC. Next: id_pc<=fetch_pc, fetch_pc<=fetch_pc+1, id_valid<=1, state<=RUN.
- RUN, priority order:
  1. hlt: imem_en=0; id_valid<=0; state<=HALT; halted<=1.
  2. take: imem_en=0; fetch_pc<=jdest; id_valid<=0. This flushes the wrong-path word. Exactly one bubble; id_pc=jdest, valid 2 cycles after the taken cycle.
  3. id_valid & stall: imem_en=0; hold fetch_pc, id_pc and id_valid. id_instr stays stable because memory holds.
  4. Otherwise (accept, or bubble with id_valid=0): imem_en=1; id_pc<=fetch_pc; fetch_pc<=fetch_pc+1; id_valid<=1.
- jflag and jdest are ignored unless accept. While stalled, no redirect occurs.
- HALT: imem_en=0, id_valid=0, halted=1. Stays until rst. stall and jflag are ignored.
- fetch_count increments on every accept, including the HLT and the taken branch. It saturates at 0xFFFF.
- PC arithmetic is modulo 2^PC_W: 0xFFF+1 -> 0x000. jdest is used as given.
- Latency: 1 cycle from imem_addr to id_instr. Steady-state throughput is 1 instruction/cycle.
- rst mid-stall or mid-redirect: all state returns to reset values next edge; the first valid instruction is at RESET_PC, 2 cycles after rst drops.

Test Plan:
- Reset then run, mem[i]=0x1000+i, no stall -> id_valid=0 in cycle 0; cycles 1..4 give id_pc 0,1,2,3 with id_instr 0x1000..0x1003; fetch_count=3 after cycle 3.
- stall high for 3 cycles while id_pc=2 -> id_pc=2, id_instr=0x1002, imem_en=0 and fetch_count frozen throughout; id_pc=3 the cycle after stall drops.
- jflag=1, jdest=0x040 while id_pc=5 unstalled -> next cycle id_valid=0 and imem_addr=0x040; following cycle id_pc=0x040, id_valid=1; pc 6 is never valid.
- jflag=1 together with stall=1 at id_pc=5 -> no redirect. Release stall with jflag still 1 -> redirect as in the previous scenario.
- HLT (0xC0F0) at id_pc=7 -> next cycle halted=1, id_valid=0, imem_en=0; these hold for 20 cycles with stall/jflag toggled; rst returns to FILL with halted=0.
- Branch to jdest=0xFFE, then straight-line -> id_pc 0xFFE, 0xFFF, 0x000, 0x001; a 70000-instruction run ends with fetch_count=0xFFFF.
